led_mode_sched: RTL and testbench

//  Controller for the 8-bit LED shifter datapath. Generates the step tick from a prescaler with
//  4 speed levels, schedules mode changes onto tick boundaries, and drives the pattern register.

---
 rtl/led_pkg.sv | 45 ++++
 rtl/led_tick_gen.sv | 64 ++++++
 rtl/led_mode_sched.sv | 122 ++++++++++++
 tb/tb_led_mode_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED shifter controller: mode and ping-pong
// direction encodings, the speed-level type, the pattern each mode starts
// from, and a helper that advances a mode by one (wrapping 3 -> 0).
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_FLOW_L = 2'd0,
        MODE_FLOW_R = 2'd1,
        MODE_PING   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef logic [1:0] speed_t;

    localparam logic [7:0] PAT_FLOW_L = 8'h01;
    localparam logic [7:0] PAT_FLOW_R = 8'h80;
    localparam logic [7:0] PAT_PING   = 8'h01;
    localparam logic [7:0] PAT_BLINK  = 8'hFF;

    function automatic logic [7:0] init_pattern(input mode_e m);
        logic [7:0] pat;
        case (m)
            MODE_FLOW_L: pat = PAT_FLOW_L;
            MODE_FLOW_R: pat = PAT_FLOW_R;
            MODE_PING:   pat = PAT_PING;
            default:     pat = PAT_BLINK;
        endcase
        return pat;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] nxt;
        nxt = m + 2'd1;
        return mode_e'(nxt);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Prescaler and speed-level register. Produces a single-cycle step strobe
// every (TICK_BASE+1) << speed cycles while not paused.
//   sys_clk    in   system clock
//   sys_rst_n  in   synchronous reset, active HIGH despite the name
//   speed_req  in   pulse: advance speed level, clear the prescaler
//   pause      in   level: freeze the prescaler
//   speed      out  current speed level
//   step       out  combinational strobe, high in the cycle the count hits limit
// -----------------------------------------------------------------------------
module led_tick_gen
    import led_pkg::*;
#(
    parameter logic [26:0] TICK_BASE = 27'd24_999_999,
    parameter int          CNT_W     = 30
) (
    input  logic   sys_clk,
    input  logic   sys_rst_n,
    input  logic   speed_req,
    input  logic   pause,
    output speed_t speed,
    output logic   step
);

    localparam logic [CNT_W-1:0] PERIOD0 = CNT_W'(TICK_BASE) + CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;
    speed_t           speed_q, speed_d;
    logic             at_limit;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        limit    = (PERIOD0 << speed_q) - CNT_W'(1);
        at_limit = (cnt_q == limit);
        // A speed change restarts the period, so it suppresses the step.
        step     = at_limit && !pause && !speed_req;
        cnt_d    = cnt_q;
        speed_d  = speed_q;
        if (speed_req) begin
            speed_d = speed_q + 2'd1;
            cnt_d   = '0;
        end else if (!pause) begin
            cnt_d = at_limit ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            cnt_q   <= '0;
            speed_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
        end
    end

    assign speed = speed_q;

endmodule

// File: rtl/led_mode_sched.sv
// -----------------------------------------------------------------------------
// led_mode_sched
// LED shifter controller. Holds the mode register, the pending-mode request,
// the ping-pong direction flag and the pattern register; the step timing
// comes from led_tick_gen.
//   sys_clk    in   system clock
//   sys_rst_n  in   synchronous reset, active HIGH despite the name
//   mode_req   in   pulse: advance mode at the next step
//   speed_req  in   pulse: advance speed level immediately
//   pause      in   level: freeze prescaler and pattern
//   led_out    out  registered LED pattern
//   mode       out  current mode (FLOW_L, FLOW_R, PING, BLINK)
//   speed      out  current speed level
//   tick       out  registered pulse, high while led_out shows a new value
// -----------------------------------------------------------------------------
module led_mode_sched
    import led_pkg::*;
#(
    parameter logic [26:0] TICK_BASE = 27'd24_999_999,
    parameter int          CNT_W     = 30
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       mode_req,
    input  logic       speed_req,
    input  logic       pause,
    output logic [7:0] led_out,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       tick
);

    logic       step;
    mode_e      mode_q, mode_d;
    mode_e      pend_mode_q, pend_mode_d;
    logic       pend_v_q, pend_v_d;
    dir_e       dir_q, dir_d;
    logic [7:0] led_q, led_d;
    logic       tick_q, tick_d;
    mode_e      req_mode;
    mode_e      target_mode;
    logic       pend_any;

    led_tick_gen #(
        .TICK_BASE (TICK_BASE),
        .CNT_W     (CNT_W)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .speed_req (speed_req),
        .pause     (pause),
        .speed     (speed),
        .step      (step)
    );

    always_comb begin
        // Requests accumulate on top of whatever is already pending; a
        // request coinciding with the step is folded in here directly.
        req_mode    = next_mode(pend_v_q ? pend_mode_q : mode_q);
        pend_any    = pend_v_q || mode_req;
        target_mode = mode_req ? req_mode : pend_mode_q;

        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_v_d    = pend_v_q;
        dir_d       = dir_q;
        led_d       = led_q;
        tick_d      = 1'b0;

        if (step) begin
            tick_d = 1'b1;
            if (pend_any) begin
                // A mode change loads the start pattern instead of shifting.
                mode_d   = target_mode;
                pend_v_d = 1'b0;
                led_d    = init_pattern(target_mode);
                dir_d    = DIR_LEFT;
            end else begin
                case (mode_q)
                    MODE_FLOW_L: led_d = {led_q[6:0], led_q[7]};
                    MODE_FLOW_R: led_d = {led_q[0], led_q[7:1]};
                    MODE_PING: begin
                        if (dir_q == DIR_LEFT) begin
                            led_d = {led_q[6:0], 1'b0};
                            if (led_d == 8'h80) dir_d = DIR_RIGHT;
                        end else begin
                            led_d = {1'b0, led_q[7:1]};
                            if (led_d == 8'h01) dir_d = DIR_LEFT;
                        end
                    end
                    default:     led_d = ~led_q;
                endcase
            end
        end else if (mode_req) begin
            pend_mode_d = req_mode;
            pend_v_d    = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            mode_q      <= MODE_FLOW_L;
            pend_mode_q <= MODE_FLOW_L;
            pend_v_q    <= 1'b0;
            dir_q       <= DIR_LEFT;
            led_q       <= PAT_FLOW_L;
            tick_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_v_q    <= pend_v_d;
            dir_q       <= dir_d;
            led_q       <= led_d;
            tick_q      <= tick_d;
        end
    end

    assign led_out = led_q;
    assign mode    = mode_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_led_mode_sched.sv
// -----------------------------------------------------------------------------
// tb_led_mode_sched
// Directed bench with a scoreboard of expected (led, mode, cycles-since-last)
// entries; each entry is popped and compared when the DUT raises tick.
// TICK_BASE = 3, so speed 0 steps every 4 cycles.
// -----------------------------------------------------------------------------
module tb_led_mode_sched;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       mode_req  = 1'b0;
    logic       speed_req = 1'b0;
    logic       pause     = 1'b0;
    logic [7:0] led_out;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] led;
        logic [1:0] mode;
        int         gap;
    } exp_t;

    exp_t sb[$];

    led_mode_sched #(
        .TICK_BASE (27'd3),
        .CNT_W     (6)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mode_req  (mode_req),
        .speed_req (speed_req),
        .pause     (pause),
        .led_out   (led_out),
        .mode      (mode),
        .speed     (speed),
        .tick      (tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] led, input logic [1:0] m, input int gap);
        exp_t e;
        e.led  = led;
        e.mode = m;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    // Counts falling edges until tick is seen, bounded so a dead DUT cannot hang.
    task automatic wait_tick(output int gap);
        logic seen;
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge sys_clk);
            gap++;
            if (tick) seen = 1'b1;
        end
        check("tick_seen", seen, 1);
    endtask

    task automatic expect_next();
        exp_t e;
        int   g;
        wait_tick(g);
        e = sb.pop_front();
        check("tick_gap", g, e.gap);
        check("led", led_out, e.led);
        check("mode", mode, e.mode);
    endtask

    task automatic drain();
        while (sb.size() != 0) expect_next();
    endtask

    task automatic pulse_mode();
        mode_req = 1'b1;
        @(negedge sys_clk);
        mode_req = 1'b0;
    endtask

    task automatic pulse_speed();
        speed_req = 1'b1;
        @(negedge sys_clk);
        speed_req = 1'b0;
    endtask

    initial begin
        // Reset state
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_led", led_out, 8'h01);
        check("rst_mode", mode, 2'd0);
        check("rst_speed", speed, 2'd0);
        check("rst_tick", tick, 1'b0);
        sys_rst_n = 1'b0;

        // Free-running FLOW_L, full rotation with 80 -> 01 wrap
        push(8'h02, 2'd0, 4); push(8'h04, 2'd0, 4); push(8'h08, 2'd0, 4);
        push(8'h10, 2'd0, 4); push(8'h20, 2'd0, 4); push(8'h40, 2'd0, 4);
        push(8'h80, 2'd0, 4); push(8'h01, 2'd0, 4);
        drain();

        // Speed 1 doubles the period and restarts the count
        pulse_speed();
        check("speed_1", speed, 2'd1);
        push(8'h02, 2'd0, 8); push(8'h04, 2'd0, 8);
        drain();

        // Three more requests wrap the speed back to 0
        pulse_speed();
        check("speed_2", speed, 2'd2);
        pulse_speed();
        check("speed_3", speed, 2'd3);
        pulse_speed();
        check("speed_wrap", speed, 2'd0);
        push(8'h08, 2'd0, 4);
        drain();

        // Two mode requests accumulate to PING, applied only at the tick
        pulse_mode();
        check("pend1_mode_held", mode, 2'd0);
        pulse_mode();
        check("pend2_mode_held", mode, 2'd0);
        push(8'h01, 2'd2, 2);
        push(8'h02, 2'd2, 4); push(8'h04, 2'd2, 4); push(8'h08, 2'd2, 4);
        push(8'h10, 2'd2, 4); push(8'h20, 2'd2, 4); push(8'h40, 2'd2, 4);
        push(8'h80, 2'd2, 4); push(8'h40, 2'd2, 4); push(8'h20, 2'd2, 4);
        push(8'h10, 2'd2, 4); push(8'h08, 2'd2, 4); push(8'h04, 2'd2, 4);
        push(8'h02, 2'd2, 4); push(8'h01, 2'd2, 4); push(8'h02, 2'd2, 4);
        drain();

        // Mode request in the step cycle is applied at that tick: PING -> BLINK
        repeat (3) @(negedge sys_clk);
        mode_req = 1'b1;
        push(8'hFF, 2'd3, 1);
        expect_next();
        mode_req = 1'b0;
        push(8'h00, 2'd3, 4); push(8'hFF, 2'd3, 4); push(8'h00, 2'd3, 4);
        drain();

        // Pause freezes count and pattern; a mode request is still accepted
        repeat (2) @(negedge sys_clk);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            check("pause_tick", tick, 1'b0);
            check("pause_led", led_out, 8'h00);
            mode_req = (i == 5);
        end
        mode_req = 1'b0;
        check("pause_mode", mode, 2'd3);
        pause = 1'b0;
        push(8'h01, 2'd0, 2);
        drain();

        // Same-cycle request FLOW_L -> FLOW_R, then full right rotation with 01 -> 80 wrap
        repeat (3) @(negedge sys_clk);
        mode_req = 1'b1;
        push(8'h80, 2'd1, 1);
        expect_next();
        mode_req = 1'b0;
        push(8'h40, 2'd1, 4); push(8'h20, 2'd1, 4); push(8'h10, 2'd1, 4);
        push(8'h08, 2'd1, 4); push(8'h04, 2'd1, 4); push(8'h02, 2'd1, 4);
        push(8'h01, 2'd1, 4); push(8'h80, 2'd1, 4);
        drain();

        // Into PING, then reset with a pending mode and a raised speed
        pulse_mode();
        push(8'h01, 2'd2, 3); push(8'h02, 2'd2, 4);
        drain();
        mode_req  = 1'b1;
        speed_req = 1'b1;
        @(negedge sys_clk);
        mode_req  = 1'b0;
        speed_req = 1'b0;
        check("pre_rst_speed", speed, 2'd1);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("mid_rst_led", led_out, 8'h01);
        check("mid_rst_mode", mode, 2'd0);
        check("mid_rst_speed", speed, 2'd0);
        check("mid_rst_tick", tick, 1'b0);
        sys_rst_n = 1'b0;
        // Pending request must be gone: plain FLOW_L shift follows
        push(8'h02, 2'd0, 4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
